hub_sys_n: RTL and testbench

HUB_SYS_N -- requirements
Module: hub_sys_n

---
 rtl/hub_pkg.sv | 26 ++
 rtl/hub_prio_enc.sv | 23 ++
 rtl/hub_sys_n.sv | 193 +++++++++++++++++++
 tb/tb_hub_sys_n.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_pkg.sv
// Shared hub definitions: system-op opcodes, request operand fields, index-width helper.
package hub_pkg;

    typedef enum logic [2:0] {
        OP_CLKSET  = 3'b000,
        OP_COGID   = 3'b001,
        OP_COGINIT = 3'b010,
        OP_COGSTOP = 3'b011,
        OP_LOCKNEW = 3'b100,
        OP_LOCKRET = 3'b101,
        OP_LOCKSET = 3'b110,
        OP_LOCKCLR = 3'b111
    } hub_op_e;

    // req_d layout: [31:4] launch pointer, [3] newx, low bits carry cog id, lock id or cfg
    localparam int unsigned REQ_DW   = 32;
    localparam int unsigned PTR_LSB  = 4;
    localparam int unsigned PTR_W    = 28;
    localparam int unsigned NEWX_BIT = 3;

    // Index width for n entries, never narrower than one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hub_prio_enc.sv
// Lowest-clear-bit search; idx is all ones and all is set when every bit is taken.
module hub_prio_enc #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          all
);

    // Scan from the top so the lowest clear bit wins
    always_comb begin
        idx = '1;
        all = 1'b1;
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (!vec[i]) begin
                idx = IW'(i);
                all = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hub_sys_n.sv
// Hub system-op unit: rotating slot, two-stage request pipeline, cog enables and lock pool.
module hub_sys_n
    import hub_pkg::*;
#(
    parameter int unsigned NCOG  = 8,
    parameter int unsigned NLOCK = 8,
    parameter int unsigned CFGW  = 8,
    localparam int unsigned IW = $clog2(NCOG),
    localparam int unsigned LW = idx_w(NLOCK),
    localparam int unsigned QW = ((IW > LW) ? IW : LW) + 1
) (
    input  logic              clk_cog,
    input  logic              nres,
    input  logic              ena_bus,
    input  logic              req_e,
    input  logic [2:0]        req_op,
    input  logic [REQ_DW-1:0] req_d,
    output logic [IW-1:0]     slot,
    output logic [QW-1:0]     sys_q,
    output logic              sys_c,
    output logic [NCOG-1:0]   bus_ack,
    output logic [NCOG-1:0]   cog_ena,
    output logic [NCOG-1:0]   ptr_w,
    output logic [PTR_W-1:0]  ptr_d,
    output logic [CFGW-1:0]   cfg
);

    // Stage-1 request latch
    logic              s1_valid;
    hub_op_e           s1_op;
    logic [REQ_DW-1:0] s1_d;
    logic [IW-1:0]     s1_req;

    // Architectural state
    logic [NCOG-1:0]   cog_en;
    logic [NLOCK-1:0]  lk_alloc;
    logic [NLOCK-1:0]  lk_st;
    logic [IW-1:0]     lk_own [NLOCK];

    // Next-state values
    logic [NCOG-1:0]   en_nx;
    logic [NCOG-1:0]   rs_mask;
    logic [NCOG-1:0]   ack_nx;
    logic [NCOG-1:0]   pw_nx;
    logic [NLOCK-1:0]  alloc_nx;
    logic [NLOCK-1:0]  st_nx;
    logic [IW-1:0]     own_nx [NLOCK];
    logic [CFGW-1:0]   cfg_nx;
    logic [QW-1:0]     q_nx;
    logic              c_nx;
    logic [PTR_W-1:0]  ptr_nx;

    // Decoded operands and search results
    logic [IW-1:0]     free_cog;
    logic              cog_all;
    logic [LW-1:0]     free_lk;
    logic              lk_all;
    logic [IW-1:0]     cog_id;
    logic [IW-1:0]     tgt_cog;
    logic [LW-1:0]     lk_id;
    logic              lk_ok;
    logic              newx;

    hub_prio_enc #(.W(NCOG), .IW(IW)) u_cog_enc (
        .vec (cog_en),
        .idx (free_cog),
        .all (cog_all)
    );

    hub_prio_enc #(.W(NLOCK), .IW(LW)) u_lock_enc (
        .vec (lk_alloc),
        .idx (free_lk),
        .all (lk_all)
    );

    // Execute the latched request and derive next state and results
    always_comb begin
        en_nx    = cog_en;
        rs_mask  = '0;
        ack_nx   = '0;
        pw_nx    = '0;
        alloc_nx = lk_alloc;
        st_nx    = lk_st;
        own_nx   = lk_own;
        cfg_nx   = cfg;
        q_nx     = sys_q;
        c_nx     = sys_c;
        ptr_nx   = ptr_d;

        newx    = s1_d[NEWX_BIT];
        cog_id  = s1_d[IW-1:0];
        tgt_cog = newx ? free_cog : cog_id;
        lk_id   = s1_d[LW-1:0];
        lk_ok   = (32'(lk_id) < NLOCK);

        if (s1_valid) begin
            ack_nx[s1_req] = 1'b1;
            q_nx           = '0;
            c_nx           = 1'b0;
            case (s1_op)
                OP_CLKSET: cfg_nx = s1_d[CFGW-1:0];
                OP_COGID:  q_nx = QW'(s1_req);
                OP_COGINIT: begin
                    q_nx = QW'(tgt_cog);
                    c_nx = cog_all;
                    if (!(newx && cog_all)) begin
                        en_nx[tgt_cog]   = 1'b1;
                        rs_mask[tgt_cog] = 1'b1;
                        pw_nx[tgt_cog]   = 1'b1;
                        ptr_nx           = s1_d[PTR_LSB +: PTR_W];
                    end
                end
                OP_COGSTOP: begin
                    q_nx          = QW'(cog_id);
                    en_nx[cog_id] = 1'b0;
                    // Auto-release treats each owned lock like a LOCKRET
                    for (int i = 0; i < int'(NLOCK); i++) begin
                        if (lk_alloc[i] && (lk_own[i] == cog_id)) begin
                            alloc_nx[i] = 1'b0;
                            st_nx[i]    = 1'b0;
                        end
                    end
                end
                OP_LOCKNEW: begin
                    q_nx = QW'(free_lk);
                    c_nx = lk_all;
                    if (!lk_all) begin
                        alloc_nx[free_lk] = 1'b1;
                        st_nx[free_lk]    = 1'b0;
                        own_nx[free_lk]   = s1_req;
                    end
                end
                OP_LOCKRET: begin
                    q_nx = QW'(lk_id);
                    if (lk_ok) begin
                        alloc_nx[lk_id] = 1'b0;
                        st_nx[lk_id]    = 1'b0;
                    end
                end
                OP_LOCKSET, OP_LOCKCLR: begin
                    q_nx = QW'(lk_id);
                    if (lk_ok) begin
                        c_nx         = lk_st[lk_id];
                        st_nx[lk_id] = (s1_op == OP_LOCKSET);
                    end
                end
                default: ;
            endcase
        end
    end

    // All state and outputs advance only on a hub slot strobe
    always_ff @(posedge clk_cog or negedge nres) begin
        if (!nres) begin
            slot     <= '0;
            s1_valid <= 1'b0;
            s1_op    <= OP_CLKSET;
            s1_d     <= '0;
            s1_req   <= '0;
            cog_en   <= NCOG'(1);
            cog_ena  <= '0;
            lk_alloc <= '0;
            lk_st    <= '0;
            for (int i = 0; i < int'(NLOCK); i++) begin
                lk_own[i] <= '0;
            end
            cfg      <= '0;
            sys_q    <= '0;
            sys_c    <= 1'b0;
            bus_ack  <= '0;
            ptr_w    <= '0;
            ptr_d    <= '0;
        end else if (ena_bus) begin
            slot     <= slot + IW'(1);
            s1_valid <= req_e;
            s1_op    <= hub_op_e'(req_op);
            s1_d     <= req_d;
            s1_req   <= slot;
            cog_en   <= en_nx;
            cog_ena  <= en_nx & ~rs_mask;
            lk_alloc <= alloc_nx;
            lk_st    <= st_nx;
            lk_own   <= own_nx;
            cfg      <= cfg_nx;
            sys_q    <= q_nx;
            sys_c    <= c_nx;
            bus_ack  <= ack_nx;
            ptr_w    <= pw_nx;
            ptr_d    <= ptr_nx;
        end
    end

endmodule

// File: tb/tb_hub_sys_n.sv
// Randomized bench for hub_sys_n against a behavioural model, plus directed literal checks.
module tb_hub_sys_n;

    localparam int unsigned NCOG  = 8;
    localparam int unsigned NLOCK = 8;
    localparam int unsigned QW    = 4;

    localparam logic [2:0] CLKSET  = 3'd0;
    localparam logic [2:0] COGID   = 3'd1;
    localparam logic [2:0] COGINIT = 3'd2;
    localparam logic [2:0] COGSTOP = 3'd3;
    localparam logic [2:0] LOCKNEW = 3'd4;
    localparam logic [2:0] LOCKRET = 3'd5;
    localparam logic [2:0] LOCKSET = 3'd6;
    localparam logic [2:0] LOCKCLR = 3'd7;

    logic        clk_cog = 1'b0;
    logic        nres    = 1'b0;
    logic        ena_bus = 1'b0;
    logic        req_e   = 1'b0;
    logic [2:0]  req_op  = 3'd0;
    logic [31:0] req_d   = 32'd0;

    logic [2:0]    slot;
    logic [QW-1:0] sys_q;
    logic          sys_c;
    logic [7:0]    bus_ack, cog_ena, ptr_w, cfg;
    logic [27:0]   ptr_d;

    // Small configuration: 4 cogs, 3 locks
    logic        s_req_e  = 1'b0;
    logic [2:0]  s_req_op = 3'd0;
    logic [31:0] s_req_d  = 32'd0;
    logic [1:0]  s_slot;
    logic [2:0]  s_sys_q;
    logic        s_sys_c;
    logic [3:0]  s_bus_ack, s_cog_ena, s_ptr_w;
    logic [27:0] s_ptr_d;
    logic [7:0]  s_cfg;

    hub_sys_n #(.NCOG(NCOG), .NLOCK(NLOCK), .CFGW(8)) u_dut (
        .clk_cog (clk_cog), .nres (nres), .ena_bus (ena_bus),
        .req_e (req_e), .req_op (req_op), .req_d (req_d),
        .slot (slot), .sys_q (sys_q), .sys_c (sys_c), .bus_ack (bus_ack),
        .cog_ena (cog_ena), .ptr_w (ptr_w), .ptr_d (ptr_d), .cfg (cfg)
    );

    hub_sys_n #(.NCOG(4), .NLOCK(3), .CFGW(8)) u_small (
        .clk_cog (clk_cog), .nres (nres), .ena_bus (ena_bus),
        .req_e (s_req_e), .req_op (s_req_op), .req_d (s_req_d),
        .slot (s_slot), .sys_q (s_sys_q), .sys_c (s_sys_c), .bus_ack (s_bus_ack),
        .cog_ena (s_cog_ena), .ptr_w (s_ptr_w), .ptr_d (s_ptr_d), .cfg (s_cfg)
    );

    always #5 clk_cog = ~clk_cog;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          cog;
        int          op;
        logic [31:0] d;
    } req_t;

    req_t        pend[$];
    int          m_slot;
    bit          m_run  [NCOG];
    bit          m_hold [NCOG];
    bit          m_used [NLOCK];
    int          m_own  [NLOCK];
    bit          m_st   [NLOCK];
    logic [2:0]  e_slot;
    logic [3:0]  e_q;
    logic        e_c;
    logic [7:0]  e_ack, e_ena, e_pw, e_cfg;
    logic [27:0] e_ptr;

    task automatic model_reset();
        m_slot = 0;
        for (int i = 0; i < int'(NCOG); i++) begin
            m_run[i]  = (i == 0);
            m_hold[i] = 1'b0;
        end
        for (int i = 0; i < int'(NLOCK); i++) begin
            m_used[i] = 1'b0;
            m_own[i]  = 0;
            m_st[i]   = 1'b0;
        end
        pend.delete();
        e_slot = '0; e_q = '0; e_c = 1'b0; e_ack = '0; e_ena = '0;
        e_pw = '0; e_cfg = '0; e_ptr = '0;
    endtask

    task automatic model_step();
        req_t r;
        int   fc, fl, t, id;
        e_ack = '0;
        e_pw  = '0;
        for (int i = 0; i < int'(NCOG); i++) m_hold[i] = 1'b0;
        if (pend.size() > 0) begin
            r  = pend.pop_front();
            e_ack[r.cog] = 1'b1;
            e_q = '0;
            e_c = 1'b0;
            fc = -1;
            for (int i = int'(NCOG) - 1; i >= 0; i--) if (!m_run[i]) fc = i;
            fl = -1;
            for (int i = int'(NLOCK) - 1; i >= 0; i--) if (!m_used[i]) fl = i;
            id = int'(r.d % 8);
            case (r.op)
                0: e_cfg = r.d[7:0];
                1: e_q = 4'(r.cog);
                2: begin
                    t   = r.d[3] ? ((fc < 0) ? 7 : fc) : id;
                    e_q = 4'(t);
                    e_c = (fc < 0);
                    if (!(r.d[3] && fc < 0)) begin
                        m_run[t]  = 1'b1;
                        m_hold[t] = 1'b1;
                        e_pw[t]   = 1'b1;
                        e_ptr     = r.d[31:4];
                    end
                end
                3: begin
                    e_q = 4'(id);
                    m_run[id] = 1'b0;
                    for (int i = 0; i < int'(NLOCK); i++)
                        if (m_used[i] && m_own[i] == id) begin
                            m_used[i] = 1'b0;
                            m_st[i]   = 1'b0;
                        end
                end
                4: begin
                    e_q = (fl < 0) ? 4'd7 : 4'(fl);
                    e_c = (fl < 0);
                    if (fl >= 0) begin
                        m_used[fl] = 1'b1;
                        m_own[fl]  = r.cog;
                        m_st[fl]   = 1'b0;
                    end
                end
                5: begin
                    e_q = 4'(id);
                    m_used[id] = 1'b0;
                    m_st[id]   = 1'b0;
                end
                default: begin
                    e_q = 4'(id);
                    e_c = m_st[id];
                    m_st[id] = (r.op == 6);
                end
            endcase
        end
        if (req_e) pend.push_back('{m_slot, int'(req_op), req_d});
        m_slot = (m_slot + 1) % int'(NCOG);
        e_slot = 3'(m_slot);
        e_ena  = '0;
        for (int i = 0; i < int'(NCOG); i++) if (m_run[i] && !m_hold[i]) e_ena[i] = 1'b1;
    endtask

    // Model advances with the hub strobe
    always @(posedge clk_cog or negedge nres) begin
        if (!nres) model_reset();
        else if (ena_bus) model_step();
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk_cog) begin
        if (chk_on) begin
            check("m_slot",    32'(slot),    32'(e_slot));
            check("m_sys_q",   32'(sys_q),   32'(e_q));
            check("m_sys_c",   32'(sys_c),   32'(e_c));
            check("m_bus_ack", 32'(bus_ack), 32'(e_ack));
            check("m_cog_ena", 32'(cog_ena), 32'(e_ena));
            check("m_ptr_w",   32'(ptr_w),   32'(e_pw));
            check("m_ptr_d",   32'(ptr_d),   32'(e_ptr));
            check("m_cfg",     32'(cfg),     32'(e_cfg));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic slot_step(input bit e, input logic [2:0] op, input logic [31:0] d);
        @(negedge clk_cog);
        ena_bus = 1'b1; req_e = e; req_op = op; req_d = d;
        @(negedge clk_cog);
        ena_bus = 1'b0; req_e = 1'b0;
    endtask

    task automatic op_any(input logic [2:0] op, input logic [31:0] d);
        slot_step(1'b1, op, d);
        slot_step(1'b0, 3'd0, 32'd0);
    endtask

    task automatic op_from(input int cog, input logic [2:0] op, input logic [31:0] d);
        for (int k = 0; k < int'(NCOG) && m_slot != cog; k++) slot_step(1'b0, 3'd0, 32'd0);
        op_any(op, d);
    endtask

    task automatic s_op(input logic [2:0] op, input logic [31:0] d);
        s_req_e = 1'b1; s_req_op = op; s_req_d = d;
        slot_step(1'b0, 3'd0, 32'd0);
        s_req_e = 1'b0;
        slot_step(1'b0, 3'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_cog);
        #2 nres = 1'b1;
        @(negedge clk_cog);
        chk_on = 1'b1;

        // Reset values and slot rotation
        check("rst_slot",    32'(slot),    32'd0);
        check("rst_cog_ena", 32'(cog_ena), 32'd0);
        check("rst_bus_ack", 32'(bus_ack), 32'd0);
        check("rst_sys_q",   32'(sys_q),   32'd0);
        for (int i = 1; i <= 8; i++) begin
            slot_step(1'b0, 3'd0, 32'd0);
            check("slot_seq",  32'(slot),    32'(i % 8));
            check("boot_ena",  32'(cog_ena), 32'h01);
        end

        // COGINIT newx from cog 0
        op_from(0, COGINIT, {28'h123, 1'b1, 3'b000});
        check("init_ptr_w",   32'(ptr_w),   32'h02);
        check("init_ptr_d",   32'(ptr_d),   32'h123);
        check("init_sys_q",   32'(sys_q),   32'd1);
        check("init_sys_c",   32'(sys_c),   32'd0);
        check("init_bus_ack", 32'(bus_ack), 32'h01);
        check("init_slot",    32'(slot),    32'd2);
        check("init_hold",    32'(cog_ena), 32'h01);
        slot_step(1'b0, 3'd0, 32'd0);
        check("init_run",     32'(cog_ena), 32'h03);
        check("init_pw_clr",  32'(ptr_w),   32'h00);
        check("init_ack_clr", 32'(bus_ack), 32'h00);

        // Fill the remaining cogs, then one more newx has nowhere to go
        for (int k = 2; k < 8; k++) begin
            op_any(COGINIT, {28'(k), 1'b1, 3'b000});
            check("fill_sys_q", 32'(sys_q), 32'(k));
        end
        op_any(COGINIT, {28'h77, 1'b1, 3'b000});
        check("full_ptr_w", 32'(ptr_w), 32'h00);
        check("full_sys_c", 32'(sys_c), 32'd1);
        check("full_sys_q", 32'(sys_q), 32'd7);
        check("full_ena",   32'(cog_ena), 32'hFF);

        // COGID and CLKSET
        op_from(5, COGID, 32'd0);
        check("cogid_q", 32'(sys_q), 32'd5);
        op_any(CLKSET, 32'h1A5);
        check("clkset_cfg", 32'(cfg), 32'hA5);

        // Locks with auto-release on COGSTOP
        op_from(2, LOCKNEW, 32'd0);
        check("lknew0_q", 32'(sys_q), 32'd0);
        check("lknew0_c", 32'(sys_c), 32'd0);
        op_from(2, LOCKNEW, 32'd0);
        check("lknew1_q", 32'(sys_q), 32'd1);
        op_any(LOCKSET, 32'd0);
        check("lkset_first", 32'(sys_c), 32'd0);
        op_any(LOCKSET, 32'd0);
        check("lkset_again", 32'(sys_c), 32'd1);
        op_any(LOCKCLR, 32'd0);
        check("lkclr_prev", 32'(sys_c), 32'd1);
        op_from(0, COGSTOP, 32'd2);
        check("stop_ena", 32'(cog_ena), 32'hFB);
        op_any(LOCKNEW, 32'd0);
        check("lknew_after_stop", 32'(sys_q), 32'd0);
        op_any(LOCKRET, 32'd0);

        // Reset in the middle of a COGINIT
        slot_step(1'b1, COGINIT, {28'h55, 1'b1, 3'b000});
        #2 nres = 1'b0;
        @(negedge clk_cog);
        check("rstmid_ptr_w", 32'(ptr_w),   32'h00);
        check("rstmid_ack",   32'(bus_ack), 32'h00);
        #2 nres = 1'b1;
        slot_step(1'b0, 3'd0, 32'd0);
        check("rel_ptr_w", 32'(ptr_w),   32'h00);
        check("rel_ack",   32'(bus_ack), 32'h00);
        check("rel_ena",   32'(cog_ena), 32'h01);
        slot_step(1'b0, 3'd0, 32'd0);
        check("rel_ptr_w2", 32'(ptr_w),   32'h00);
        check("rel_ack2",   32'(bus_ack), 32'h00);

        // Out-of-range lock id on the 4-cog / 3-lock instance
        s_op(LOCKSET, 32'd3);
        check("s_lk3_c", 32'(s_sys_c), 32'd0);
        for (int k = 0; k < 3; k++) begin
            s_op(LOCKSET, 32'(k));
            check("s_lk_clear", 32'(s_sys_c), 32'd0);
        end
        s_op(LOCKSET, 32'd2);
        check("s_lk2_set", 32'(s_sys_c), 32'd1);
        for (int k = 0; k < 3; k++) begin
            s_op(LOCKNEW, 32'd0);
            check("s_lknew_q", 32'(s_sys_q), 32'(k));
        end
        s_op(LOCKNEW, 32'd0);
        check("s_lknew_full_q", 32'(s_sys_q), 32'd3);
        check("s_lknew_full_c", 32'(s_sys_c), 32'd1);
        s_op(LOCKRET, 32'd3);
        s_op(LOCKNEW, 32'd0);
        check("s_lkret3_noop", 32'(s_sys_c), 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk_cog);
            ena_bus = ($urandom_range(0, 2) != 0);
            req_e   = ($urandom_range(0, 3) != 0);
            req_op  = 3'($urandom_range(0, 7));
            req_d   = $urandom;
        end
        @(negedge clk_cog);
        ena_bus = 1'b0;
        req_e   = 1'b0;
        @(negedge clk_cog);
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
